// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled WIDTH-bit period counter with shadowed period, up/down/up-down
// modes, and a phase-load sync input so timebases can be daisy-chained through o_sync.
module pwm_timebase #(
  parameter int                WIDTH        = 16,
  parameter int                PRESCALE_W   = 8,
  parameter logic [WIDTH-1:0]  RESET_PERIOD = {WIDTH{1'b1}}
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [WIDTH-1:0]      i_period,
  input  logic                  i_period_wr,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [WIDTH-1:0]      i_phase,
  input  logic                  i_sync_in,
  input  logic                  i_sync_in_en,
  input  logic                  i_sync_out_en,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_dir,
  output logic [WIDTH-1:0]      o_period_active,
  output logic                  o_zero,
  output logic                  o_top,
  output logic                  o_sync
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_UPDN = 2'b11
  } mode_e;

  mode_e                  mode;
  logic [WIDTH-1:0]       count_q, count_d;
  logic [WIDTH-1:0]       shadow_q, shadow_d;
  logic [WIDTH-1:0]       active_q, active_d;
  logic [PRESCALE_W-1:0]  pre_q, pre_d;
  logic                   dir_q, dir_d;
  logic                   sync_q, sync_d;
  logic                   tick, sync_hit, boundary;
  logic [WIDTH-1:0]       p_minus_1, phase_clamped;

  assign mode          = mode_e'(i_mode);
  // >= so that shrinking i_prescale below the running prescaler still ticks at once
  assign tick          = i_en && (mode != MODE_OFF) && (pre_q >= i_prescale);
  assign sync_hit      = i_en && i_sync_in_en && i_sync_in && (mode != MODE_OFF);
  assign p_minus_1     = active_q - WIDTH'(1);
  assign phase_clamped = (i_phase > active_q) ? active_q : i_phase;

  always_comb begin
    count_d  = count_q;
    dir_d    = dir_q;
    pre_d    = pre_q;
    active_d = active_q;
    sync_d   = 1'b0;
    boundary = 1'b0;
    shadow_d = i_period_wr ? i_period : shadow_q;

    if (i_en) begin
      if (mode == MODE_OFF) begin
        pre_d    = '0;
        dir_d    = 1'b0;
        active_d = shadow_q;
      end else if (sync_hit) begin
        count_d = phase_clamped;
        pre_d   = '0;
        dir_d   = (mode == MODE_DOWN);
        sync_d  = 1'b1;
      end else if (tick) begin
        pre_d = '0;
        unique case (mode)
          MODE_UP: begin
            dir_d = 1'b0;
            if (count_q >= active_q) begin
              count_d  = '0;
              boundary = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
          MODE_DOWN: begin
            dir_d = 1'b1;
            if (count_q == '0) begin
              count_d  = active_q;
              boundary = 1'b1;
            end else if (count_q > active_q) begin
              count_d = active_q;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
          MODE_UPDN: begin
            if (!dir_q) begin
              if (count_q >= active_q) begin
                // P of 0 or 1: the turn-around lands on 0, so it is also the period start
                if (active_q <= WIDTH'(1)) begin
                  count_d  = '0;
                  dir_d    = 1'b0;
                  boundary = 1'b1;
                end else begin
                  count_d = p_minus_1;
                  dir_d   = 1'b1;
                end
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end else begin
              if (count_q == WIDTH'(1)) begin
                count_d  = '0;
                dir_d    = 1'b0;
                boundary = 1'b1;
              end else if (count_q == '0) begin
                count_d = WIDTH'(1);
                dir_d   = 1'b0;
              end else if (count_q > active_q) begin
                count_d = active_q;
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
          end
          default: ;
        endcase
        if (boundary) begin
          sync_d   = 1'b1;
          active_d = shadow_q;
        end
      end else begin
        pre_d = pre_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q  <= '0;
      dir_q    <= 1'b0;
      pre_q    <= '0;
      shadow_q <= RESET_PERIOD;
      active_q <= RESET_PERIOD;
      sync_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      dir_q    <= dir_d;
      pre_q    <= pre_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign o_count         = count_q;
  assign o_dir           = dir_q;
  assign o_period_active = active_q;
  assign o_zero          = (count_q == '0);
  assign o_top           = (count_q == active_q);
  assign o_sync          = i_sync_out_en & sync_q & i_en;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed bench for pwm_timebase: mode sequences, shadow period timing, sync-in, reset, enable.
module tb_pwm_timebase;
  localparam int WIDTH = 16;
  localparam int PW    = 8;

  logic             i_clk = 1'b0;
  logic             i_reset, i_en, i_period_wr, i_sync_in, i_sync_in_en, i_sync_out_en;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_period, i_phase;
  logic [PW-1:0]    i_prescale;
  logic [WIDTH-1:0] o_count, o_period_active;
  logic             o_dir, o_zero, o_top, o_sync;

  int tests = 0;
  int fails = 0;

  int up_cnt[5]    = '{1, 2, 3, 0, 1};
  int up_syn[5]    = '{0, 0, 0, 1, 0};
  int dn_cnt[18]   = '{0,0,4, 4,4,3, 3,3,2, 2,2,1, 1,1,0, 0,0,4};
  int ud_cnt[7]    = '{1, 2, 3, 2, 1, 0, 1};
  int ud_dir[7]    = '{0, 0, 0, 1, 1, 0, 0};
  int ud_syn[7]    = '{0, 0, 0, 0, 0, 1, 0};
  int ud1_cnt[4]   = '{1, 0, 1, 0};
  int ud1_syn[4]   = '{0, 1, 0, 1};

  pwm_timebase #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_mode(i_mode),
    .i_period(i_period), .i_period_wr(i_period_wr), .i_prescale(i_prescale),
    .i_phase(i_phase), .i_sync_in(i_sync_in), .i_sync_in_en(i_sync_in_en),
    .i_sync_out_en(i_sync_out_en), .o_count(o_count), .o_dir(o_dir),
    .o_period_active(o_period_active), .o_zero(o_zero), .o_top(o_top), .o_sync(o_sync)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #3;
    i_reset = 1'b0;
  endtask

  // Load a period while OFF: shadow at the first edge, active at the second.
  task automatic wr_period(input logic [WIDTH-1:0] p);
    i_mode      = 2'b00;
    i_period    = p;
    i_period_wr = 1'b1;
    step();
    i_period_wr = 1'b0;
    step();
  endtask

  initial begin
    i_reset = 1'b1; i_en = 1'b1; i_mode = 2'b00; i_period = '0; i_period_wr = 1'b0;
    i_prescale = '0; i_phase = '0; i_sync_in = 1'b0; i_sync_in_en = 1'b0;
    i_sync_out_en = 1'b1;
    #2;
    chk("rst_count",  o_count, 0);
    chk("rst_dir",    o_dir, 0);
    chk("rst_active", o_period_active, 16'hFFFF);
    chk("rst_zero",   o_zero, 1);
    chk("rst_top",    o_top, 0);
    chk("rst_sync",   o_sync, 0);
    #10;
    i_reset = 1'b0;

    // UP, P=3
    wr_period(3);
    chk("up_active", o_period_active, 3);
    i_mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("up_cnt%0d", i), o_count, up_cnt[i]);
      chk($sformatf("up_sync%0d", i), o_sync, up_syn[i]);
      chk($sformatf("up_top%0d", i), o_top, (up_cnt[i] == 3) ? 1 : 0);
    end

    // DOWN, P=4, prescale 2
    do_reset();
    wr_period(4);
    i_prescale = 8'd2;
    i_mode = 2'b10;
    for (int i = 0; i < 18; i++) begin
      step();
      chk($sformatf("dn_cnt%0d", i), o_count, dn_cnt[i]);
      chk($sformatf("dn_sync%0d", i), o_sync, (i == 2 || i == 17) ? 1 : 0);
      chk($sformatf("dn_dir%0d", i), o_dir, (i >= 2) ? 1 : 0);
    end

    // UP_DOWN, P=3
    do_reset();
    wr_period(3);
    i_prescale = '0;
    i_mode = 2'b11;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("ud_cnt%0d", i), o_count, ud_cnt[i]);
      chk($sformatf("ud_dir%0d", i), o_dir, ud_dir[i]);
      chk($sformatf("ud_sync%0d", i), o_sync, ud_syn[i]);
    end

    // UP_DOWN, P=1
    do_reset();
    wr_period(1);
    i_mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ud1_cnt%0d", i), o_count, ud1_cnt[i]);
      chk($sformatf("ud1_sync%0d", i), o_sync, ud1_syn[i]);
    end

    // UP_DOWN, P=0
    do_reset();
    wr_period(0);
    chk("ud0_top", o_top, 1);
    i_mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ud0_cnt%0d", i), o_count, 0);
      chk($sformatf("ud0_sync%0d", i), o_sync, 1);
    end

    // Shadow write mid-period, UP P=10 -> 5
    do_reset();
    wr_period(10);
    i_mode = 2'b01;
    repeat (4) step();
    chk("sh_cnt4", o_count, 4);
    i_period = 16'd5;
    i_period_wr = 1'b1;
    step();
    i_period_wr = 1'b0;
    chk("sh_cnt5", o_count, 5);
    chk("sh_act_old", o_period_active, 10);
    repeat (5) step();
    chk("sh_cnt10", o_count, 10);
    chk("sh_act_10", o_period_active, 10);
    chk("sh_top10", o_top, 1);
    step();
    chk("sh_wrap", o_count, 0);
    chk("sh_wrap_sync", o_sync, 1);
    chk("sh_act_new", o_period_active, 5);
    repeat (5) step();
    chk("sh_cnt_p5", o_count, 5);
    step();
    chk("sh_wrap2", o_count, 0);
    chk("sh_wrap2_sync", o_sync, 1);

    // Sync-in, UP P=10, prescale 1
    do_reset();
    wr_period(10);
    i_prescale = 8'd1;
    i_mode = 2'b01;
    repeat (5) step();
    chk("si_cnt2", o_count, 2);
    i_sync_in_en = 1'b1;
    i_sync_in = 1'b1;
    i_phase = 16'd7;
    step();
    i_sync_in = 1'b0;
    chk("si_cnt7", o_count, 7);
    chk("si_sync", o_sync, 1);
    step();
    chk("si_hold7", o_count, 7);
    chk("si_sync_off", o_sync, 0);
    step();
    chk("si_cnt8", o_count, 8);
    i_phase = 16'd20;
    i_sync_in = 1'b1;
    step();
    i_sync_in = 1'b0;
    chk("si_clamp", o_count, 10);
    chk("si_clamp_sync", o_sync, 1);
    step();
    chk("si_hold10", o_count, 10);
    step();
    chk("si_wrap", o_count, 0);
    chk("si_wrap_sync", o_sync, 1);
    i_sync_in_en = 1'b0;

    // Async reset mid-count
    step();
    step();
    chk("ar_cnt1", o_count, 1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("ar_count",  o_count, 0);
    chk("ar_active", o_period_active, 16'hFFFF);
    chk("ar_zero",   o_zero, 1);
    chk("ar_sync",   o_sync, 0);
    i_reset = 1'b0;

    // Enable low freezes state and masks o_sync
    wr_period(3);
    i_prescale = '0;
    i_mode = 2'b01;
    repeat (4) step();
    chk("en_cnt0", o_count, 0);
    chk("en_sync_hi", o_sync, 1);
    i_en = 1'b0;
    #1;
    chk("en_sync_mask", o_sync, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("en_frz%0d", i), o_count, 0);
      chk($sformatf("en_frz_sync%0d", i), o_sync, 0);
    end
    i_en = 1'b1;
    step();
    chk("en_resume", o_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
